// File: rtl/wb_arb_pkg.sv
// =====================================================================
// wb_arb_pkg: shared types and constants for the two-master arbiter.
// Revision 1.0
// =====================================================================
`default_nettype none

package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  localparam int WDOG_W = 8;

endpackage

`default_nettype wire

// File: rtl/wb_rr_pick.sv
// =====================================================================
// wb_rr_pick: two-way round-robin pick; the master not granted last wins a tie.
// Revision 1.0
// =====================================================================
`default_nettype none

module wb_rr_pick
  import wb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_m1,
  output logic [1:0] win
);

  always_comb begin
    win = GNT_NONE;
    case (req)
      2'b01:   win = GNT_M0;
      2'b10:   win = GNT_M1;
      2'b11:   win = last_m1 ? GNT_M0 : GNT_M1;
      default: win = GNT_NONE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wb_bus_arbiter.sv
// =====================================================================
// wb_bus_arbiter: two-master Wishbone arbiter with locked bursts.
// Optional slave watchdog compiled in with WB_ARB_TIMEOUT_EN. Revision 1.0
// =====================================================================
`default_nettype none

module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m0_dat_o,
  output logic [31:0] m1_dat_o,
  input  logic        m0_we_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m0_stb_i,
  input  logic        m1_stb_i,
  input  logic        m0_cyc_i,
  input  logic        m1_cyc_i,
  output logic        m0_ack_o,
  output logic        m1_ack_o,
  output logic        m0_err_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  gnt_o
);

  arb_state_t state, state_nxt;
  logic [1:0] gnt, gnt_nxt;
  logic       last_m1, last_m1_nxt;
  logic [1:0] req, win;
  logic       busy, sel_m1, own_cyc, timeout;

  assign req     = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
  assign busy    = (state == BUSY);
  assign sel_m1  = gnt[1];
  assign own_cyc = sel_m1 ? m1_cyc_i : m0_cyc_i;
  assign gnt_o   = gnt;

  wb_rr_pick u_pick (
    .req     (req),
    .last_m1 (last_m1),
    .win     (win)
  );

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    if (busy) begin
      if (sel_m1) begin
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
        s_we_o  = m1_we_i;
        s_stb_o = m1_stb_i;
        s_cyc_o = m1_cyc_i;
      end else begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_we_o  = m0_we_i;
        s_stb_o = m0_stb_i;
        s_cyc_o = m0_cyc_i;
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES);
  logic [WDOG_W-1:0] wdog;

  // An ack/err arriving in the limit cycle wins over the timeout.
  assign timeout = busy & s_stb_o & ~s_ack_i & ~s_err_i & (wdog == WDOG_LIMIT);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)
      wdog <= '0;
    else if ((state_nxt != BUSY) || s_ack_i || s_err_i)
      wdog <= '0;
    else if (s_stb_o)
      wdog <= wdog + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    last_m1_nxt = last_m1;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt   = BUSY;
          gnt_nxt     = win;
          last_m1_nxt = win[1];
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          state_nxt = IDLE;
          gnt_nxt   = GNT_NONE;
        end else if (timeout) begin
          state_nxt = ABORT;
        end
      end
      ABORT: begin
        if (!own_cyc) begin
          state_nxt = IDLE;
          gnt_nxt   = GNT_NONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state   <= IDLE;
      gnt     <= GNT_NONE;
      last_m1 <= 1'b1;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      last_m1 <= last_m1_nxt;
    end
  end

  // Slave responses reach only the granted master, and only while the slave is live.
  assign m0_ack_o = busy & ~sel_m1 & s_ack_i;
  assign m1_ack_o = busy &  sel_m1 & s_ack_i;
  assign m0_err_o = busy & ~sel_m1 & (s_err_i | timeout);
  assign m1_err_o = busy &  sel_m1 & (s_err_i | timeout);
  assign m0_dat_o = (busy & ~sel_m1) ? s_dat_i : '0;
  assign m1_dat_o = (busy &  sel_m1) ? s_dat_i : '0;

endmodule

`default_nettype wire

// File: doc/wb_bus_arbiter.md
WB_BUS_ARBITER -- requirements
Module: wb_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: slave-response watchdog limit in cycles, legal range 1..255.
REQ-002 SHALL have port wb_clk_i, in, 1: the single clock.
REQ-003 SHALL have port wb_rst_ni, in, 1: reset, asynchronous, active-low.
REQ-004 SHALL have ports m0_adr_i and m1_adr_i, in, 32: master addresses.
REQ-005 SHALL have ports m0_dat_i and m1_dat_i, in, 32: master write data.
REQ-006 SHALL have ports m0_dat_o and m1_dat_o, out, 32: read data returned to each master.
REQ-007 SHALL have ports m0_we_i/m1_we_i (in, 1) and m0_sel_i/m1_sel_i (in, 4): write enable and byte selects.
REQ-008 SHALL have ports m0_stb_i/m1_stb_i and m0_cyc_i/m1_cyc_i, in, 1: strobe and cycle per master.
REQ-009 SHALL have ports m0_ack_o/m1_ack_o and m0_err_o/m1_err_o, out, 1: acknowledge and error per master.
REQ-010 SHALL have slave-side ports s_adr_o (out, 32), s_dat_o (out, 32), s_dat_i (in, 32), s_we_o (out, 1), s_sel_o (out, 4), s_stb_o (out, 1), s_cyc_o (out, 1), s_ack_i (in, 1), s_err_i (in, 1).
REQ-011 SHALL have port gnt_o, out, 2: one-hot grant, 2'b00 when the bus is idle.

Function
REQ-012 SHALL implement a registered state machine with states IDLE, BUSY and ABORT.
REQ-013 In IDLE, a master is requesting when its cyc_i and stb_i are both high; with any request, the arbiter SHALL register the grant and enter BUSY on the next edge.
REQ-014 Simultaneous requests SHALL be resolved round-robin: the master that was not granted last wins; after reset the last-granted pointer SHALL be master 1.
REQ-015 In BUSY, s_* outputs SHALL be a combinational mux of the granted master's signals, so the slave sees stb one cycle after the request.
REQ-016 s_ack_i, s_err_i and s_dat_i SHALL be routed combinationally to the granted master only; the other master SHALL see ack/err low and dat_o 0.
REQ-017 Outside BUSY, s_stb_o, s_cyc_o and s_we_o SHALL be low.
REQ-018 Grant SHALL hold for as long as the granted master keeps cyc_i high, including across multiple stb phases; this provides a locked burst.
REQ-019 When the granted master drops cyc_i, the arbiter SHALL return to IDLE on the next edge, giving one dead cycle before any regrant.
REQ-020 When cyc_i drops in the same cycle as s_ack_i, the ack SHALL still pass to the master and the release SHALL proceed normally.
REQ-021 A request from the non-granted master during BUSY SHALL be ignored until the next IDLE, with no starvation: it SHALL win that arbitration.

Reset
REQ-022 On wb_rst_ni low, asynchronously: state=IDLE, gnt_o=0, last-granted=1, watchdog=0, every s_* and m*_ output low/zero.
REQ-023 A reset asserted mid-transfer SHALL drop s_cyc_o and s_stb_o immediately, with no ack generated.

Configuration
REQ-024 Macro WB_ARB_TIMEOUT_EN SHALL compile the watchdog in or out.
REQ-025 With WB_ARB_TIMEOUT_EN, the 8-bit watchdog SHALL count cycles in BUSY with s_stb_o high and neither s_ack_i nor s_err_i high, and SHALL clear on ack, err or leaving BUSY.
REQ-026 With WB_ARB_TIMEOUT_EN, when the watchdog equals TIMEOUT_CYCLES the arbiter SHALL pulse the granted master's err_o for one cycle, force s_stb_o/s_cyc_o low on the next edge, and enter ABORT.
REQ-027 With WB_ARB_TIMEOUT_EN, ABORT SHALL hold the grant with the slave idle until the master drops cyc_i, then return to IDLE.
REQ-028 Without WB_ARB_TIMEOUT_EN, there SHALL be no counter, ABORT SHALL be unreachable, and err_o SHALL carry only s_err_i.

Structure
REQ-029 Shared package wb_arb_pkg SHALL hold the state enum (IDLE, BUSY, ABORT), the grant encodings and the watchdog width constant.
REQ-030 The round-robin decision SHALL be a sub-module, wb_rr_pick (2 requests, last-granted pointer in, one-hot winner out); the rest is flat.

Verification
REQ-031 Bench SHALL cover: after reset, m0 and m1 request together -> gnt_o=01; m1 is served after m0 drops cyc, with exactly one dead cycle.
REQ-032 Bench SHALL cover: m1 holds cyc across three stb/ack reads while m0 requests -> gnt_o stays 10 throughout; m0 is granted on the 2nd edge after m1 drops cyc.
REQ-033 Bench SHALL cover: m0 write to adr 0x10 with dat 0xDEADBEEF and sel 0xF -> slave sees identical values and we=1; the ack reaches m0 only.
REQ-034 Bench SHALL cover, with WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4: slave never acks -> m0_err_o pulses in the 5th stb cycle, s_cyc_o is low the next cycle, and the arbiter is IDLE after m0 drops cyc.
REQ-035 Bench SHALL cover: wb_rst_ni pulsed low mid-transfer -> s_cyc_o=0 within the same cycle, gnt_o=00, and a subsequent simultaneous request grants m0.
REQ-036 Bench SHALL cover: slave asserts s_err_i -> m1_err_o=1 the same cycle, m1_ack_o=0, and the grant holds until m1 drops cyc.
